wbm_charlie7x5_loader: RTL and testbench
========================================

// Module: wbm_charlie7x5_loader
// PURPOSE
//  Upstream feeder for the charlie7x5 Wishbone slave. Accepts a 5-row frame as a
//  valid/ready byte stream (bit c of row byte = column c pixel) and buffers it.
//  Then writes it into the display slave as five Wishbone B4 pipelined writes, adr 0..4.
//  Reports completion and bus timeouts; drops into any design driving the display.
// PARAMETERS
//  ROWS        5    rows per frame = writes per burst
//  ADR_W       4    width of wbm_adr_o
//  TIMEOUT     255  cycles without stall-free issue or ack before burst is aborted
// PORTS
//  wbm_clk_i      in   1   single clock
//  wbm_rst_ni     in   1   reset, asynchronous, active-low
//  pix_valid_i    in   1   upstream byte valid
//  pix_data_i     in   8   row byte, row index = arrival order in frame
//  pix_last_i     in   1   marks final byte of frame
//  pix_ready_o    out  1   byte accepted when valid && ready
//  wbm_cyc_o      out  1   bus cycle
//  wbm_stb_o      out  1   strobe (pipelined)
//  wbm_we_o       out  1   constant 1 while cyc, else 0
//  wbm_adr_o      out  ADR_W  row address
//  wbm_sel_o      out  4   4'b0001 while stb, else 0
//  wbm_dat_o      out  32  {24'b0, row byte}
//  wbm_stall_i    in   1   slave stall
//  wbm_ack_i      in   1   slave ack
//  busy_o         out  1   high in SEND
//  done_o         out  1   1-cycle pulse: all ROWS acks received
//  err_o          out  1   1-cycle pulse: timeout abort
// BEHAVIOUR
//  Reset (async assert, sync-released): state FILL, all outputs 0 except
//   pix_ready_o=1 after release; buffer rows cleared to 0; counters 0.
//  FILL: pix_ready_o=1. Each accepted byte -> buf[widx], widx++.
//   - pix_last_i at widx<ROWS-1: rows widx+1..ROWS-1 forced to 0; go SEND.
//   - byte at widx=ROWS-1: go SEND regardless of pix_last_i.
//   - bytes beyond a frame start the next frame (no implicit drop).
//   - transition to SEND registered; first stb the cycle after last accept.
//  SEND: pix_ready_o=0, cyc=1. stb=1 while issued<ROWS; adr=issued, dat=buf[issued].
//   - issued++ when stb && !stall (adr/dat held stable while stalled).
//   - acked++ on ack_i when acked<issued; acks with none outstanding ignored.
//   - ack and issue in the same cycle both counted.
//   - acked==ROWS: cyc/stb drop next edge, done_o pulses with it, back to FILL.
//  Timeout: tcnt clears on any issue or ack, else increments in SEND. At
//   tcnt==TIMEOUT: cyc/stb drop, err_o pulses, frame discarded, widx=0, FILL.
//  Width rules: widx/issued/acked $clog2(ROWS+1) bits; adr zero-extended to ADR_W.
//  Reset mid-burst: cyc/stb/we/sel fall immediately (async); no done/err pulse.
//  done_o and err_o never both high in the same cycle.
// STRUCTURE
//  Package charlie7x5_pkg: ROWS, COLS=7, row-byte width, FSM state enum
//   {FILL, SEND}, WB sel constant; shared with the display slave.
//  One sub-module: wbm_burst_counter (issue/ack/timeout counters, done/err).
//  Frame buffer and FILL logic stay in top.
// TESTING
//  1 Five bytes 0x01,0x02,0x04,0x08,0x10, stall=0, ack 1 cycle after stb ->
//    adr 0..4 with matching dat, done_o once, cyc low after 5th ack.
//  2 Short frame 0x7F with last -> writes 0x7F, 0,0,0,0 to adr 0..4.
//  3 stall=1 for 3 cycles on adr 2 -> adr/dat held at 2/buf[2]; 5 writes total.
//  4 Slave never acks -> after 255 idle cycles cyc=0, err_o pulse, ready=1.
//  5 Reset low mid-burst after 2 acks -> cyc/stb 0 same cycle; next frame from adr 0.
//  6 Back-to-back: 10 bytes streamed, ready stalls upstream in SEND -> two bursts
//    in order, two done_o pulses, no byte lost.

Source files
------------

// File: rtl/charlie7x5_pkg.sv
// Shared definitions for the charlie7x5 display slave and its Wishbone frame loader.
package charlie7x5_pkg;

  localparam int unsigned ROWS  = 5;
  localparam int unsigned COLS  = 7;
  localparam int unsigned ROW_W = 8;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned CNT_W = $clog2(ROWS + 1);

  localparam logic [SEL_W-1:0] WB_SEL = 4'b0001;

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } state_e;

  typedef logic [ROW_W-1:0] row_t;

  // Row byte sits in the low lane of the data bus.
  function automatic logic [DAT_W-1:0] wb_dat(input row_t r);
    return DAT_W'(r);
  endfunction

endpackage

// File: rtl/wbm_burst_counter.sv
// Issue/ack/timeout bookkeeping for one ROWS-long pipelined write burst.
module wbm_burst_counter
  import charlie7x5_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  input  logic             ack,
  output logic             cyc,
  output logic             stb,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] issued_nxt_c,
  output logic             cyc_nxt_c,
  output logic             stb_nxt_c,
  output logic             end_c
);

  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0]  issued_q, acked_q, acked_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              issue_fire, ack_ok, done_d, err_d;

  always_comb begin
    issue_fire   = stb && !stall;
    ack_ok       = cyc && ack && (acked_q < issued_q);
    issued_nxt_c = issued_q + CNT_W'(issue_fire);
    acked_d      = acked_q + CNT_W'(ack_ok);
    tcnt_d       = '0;
    if (cyc && !issue_fire && !ack_ok) begin
      tcnt_d = tcnt_q + 1'b1;
    end
    // An ack always clears the idle counter, so done and err cannot coincide.
    done_d    = cyc && (acked_d == CNT_W'(ROWS));
    err_d     = cyc && !done_d && (tcnt_d == TCNT_W'(TIMEOUT));
    end_c     = done_d || err_d;
    cyc_nxt_c = cyc;
    if (start) begin
      issued_nxt_c = '0;
      acked_d      = '0;
      tcnt_d       = '0;
      cyc_nxt_c    = 1'b1;
    end else if (end_c) begin
      issued_nxt_c = '0;
      acked_d      = '0;
      tcnt_d       = '0;
      cyc_nxt_c    = 1'b0;
    end
    stb_nxt_c = cyc_nxt_c && (issued_nxt_c < CNT_W'(ROWS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q <= '0;
      acked_q  <= '0;
      tcnt_q   <= '0;
      cyc      <= 1'b0;
      stb      <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      issued_q <= issued_nxt_c;
      acked_q  <= acked_d;
      tcnt_q   <= tcnt_d;
      cyc      <= cyc_nxt_c;
      stb      <= stb_nxt_c;
      done     <= done_d;
      err      <= err_d;
    end
  end

endmodule

// File: rtl/wbm_charlie7x5_loader.sv
// Buffers a 5-row frame from a valid/ready byte stream, then writes it to the
// charlie7x5 display slave as a Wishbone B4 pipelined burst to adr 0..ROWS-1.
module wbm_charlie7x5_loader
  import charlie7x5_pkg::*;
#(
  parameter int unsigned ADR_W   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             wbm_clk_i,
  input  logic             wbm_rst_ni,
  input  logic             pix_valid_i,
  input  logic [ROW_W-1:0] pix_data_i,
  input  logic             pix_last_i,
  output logic             pix_ready_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [ADR_W-1:0] wbm_adr_o,
  output logic [SEL_W-1:0] wbm_sel_o,
  output logic [DAT_W-1:0] wbm_dat_o,
  input  logic             wbm_stall_i,
  input  logic             wbm_ack_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  state_e           state_q, state_d;
  row_t             rows_q [ROWS];
  row_t             rows_d [ROWS];
  logic [CNT_W-1:0] widx_q, widx_d, issued_nxt;
  logic             accept, start, burst_end, cyc_nxt, stb_nxt;
  logic             ready_d, busy_d, we_d;
  logic [ADR_W-1:0] adr_d;
  logic [SEL_W-1:0] sel_d;
  logic [DAT_W-1:0] dat_d;

  wbm_burst_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_cnt (
    .clk          (wbm_clk_i),
    .rst_n        (wbm_rst_ni),
    .start        (start),
    .stall        (wbm_stall_i),
    .ack          (wbm_ack_i),
    .cyc          (wbm_cyc_o),
    .stb          (wbm_stb_o),
    .done         (done_o),
    .err          (err_o),
    .issued_nxt_c (issued_nxt),
    .cyc_nxt_c    (cyc_nxt),
    .stb_nxt_c    (stb_nxt),
    .end_c        (burst_end)
  );

  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    rows_d  = rows_q;
    start   = 1'b0;
    accept  = pix_valid_i && pix_ready_o;
    case (state_q)
      FILL: begin
        if (accept) begin
          rows_d[widx_q] = pix_data_i;
          widx_d         = widx_q + 1'b1;
          if (pix_last_i || (widx_q == CNT_W'(ROWS - 1))) begin
            // Short frame: rows not yet delivered are blanked.
            for (int unsigned r = 0; r < ROWS; r++) begin
              if (CNT_W'(r) > widx_q) begin
                rows_d[r] = '0;
              end
            end
            widx_d  = '0;
            start   = 1'b1;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (burst_end) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    // Bus payload follows the next issue index so it stays put while stalled.
    ready_d = (state_d == FILL);
    busy_d  = (state_d == SEND);
    we_d    = cyc_nxt;
    sel_d   = stb_nxt ? WB_SEL : '0;
    adr_d   = '0;
    dat_d   = '0;
    if (stb_nxt) begin
      adr_d = ADR_W'(issued_nxt);
      dat_d = wb_dat(rows_d[issued_nxt]);
    end
  end

  always_ff @(posedge wbm_clk_i or negedge wbm_rst_ni) begin
    if (!wbm_rst_ni) begin
      state_q     <= FILL;
      widx_q      <= '0;
      for (int unsigned r = 0; r < ROWS; r++) begin
        rows_q[r] <= '0;
      end
      pix_ready_o <= 1'b0;
      busy_o      <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_sel_o   <= '0;
      wbm_dat_o   <= '0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      rows_q      <= rows_d;
      pix_ready_o <= ready_d;
      busy_o      <= busy_d;
      wbm_we_o    <= we_d;
      wbm_adr_o   <= adr_d;
      wbm_sel_o   <= sel_d;
      wbm_dat_o   <= dat_d;
    end
  end

endmodule

// File: tb/tb_wbm_charlie7x5_loader.sv
// Directed and randomized frames through the loader against a frame-level write model.
module tb_wbm_charlie7x5_loader;
  import charlie7x5_pkg::*;

  localparam int unsigned ADR_W   = 4;
  localparam int unsigned TIMEOUT = 255;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pix_valid, pix_last, pix_ready;
  logic [7:0]       pix_data;
  logic             wbm_cyc, wbm_stb, wbm_we, wbm_stall, wbm_ack;
  logic [ADR_W-1:0] wbm_adr;
  logic [3:0]       wbm_sel;
  logic [31:0]      wbm_dat;
  logic             busy, done, err;

  always #5 clk = ~clk;

  wbm_charlie7x5_loader #(.ADR_W(ADR_W), .TIMEOUT(TIMEOUT)) dut (
    .wbm_clk_i   (clk),
    .wbm_rst_ni  (rst_n),
    .pix_valid_i (pix_valid),
    .pix_data_i  (pix_data),
    .pix_last_i  (pix_last),
    .pix_ready_o (pix_ready),
    .wbm_cyc_o   (wbm_cyc),
    .wbm_stb_o   (wbm_stb),
    .wbm_we_o    (wbm_we),
    .wbm_adr_o   (wbm_adr),
    .wbm_sel_o   (wbm_sel),
    .wbm_dat_o   (wbm_dat),
    .wbm_stall_i (wbm_stall),
    .wbm_ack_i   (wbm_ack),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  int checks = 0;
  int failures = 0;

  // Slave model and bus monitor state
  int          cyc_no = 0, done_cnt = 0, err_cnt = 0, ack_cnt = 0, both_cnt = 0;
  int          last_fire_cyc = 0, err_cyc = 0;
  bit          pend = 0, ack_en = 1, rand_stall = 0;
  int          stall_adr = -1, stall_left = 0;
  logic [31:0] wr_adr_q[$], wr_dat_q[$], st_adr_q[$], st_dat_q[$];

  always @(negedge clk) begin
    cyc_no++;
    if (done) done_cnt++;
    if (err) begin
      err_cnt++;
      err_cyc = cyc_no;
    end
    if (done && err) both_cnt++;
    if (!rst_n) begin
      pend = 0;
      wbm_ack = 1'b0;
      wbm_stall = 1'b0;
    end else begin
      if (wbm_cyc && wbm_stb && stall_left > 0 && int'(wbm_adr) == stall_adr) begin
        wbm_stall = 1'b1;
        stall_left--;
      end else if (rand_stall && wbm_cyc) begin
        wbm_stall = ($urandom_range(3) == 0);
      end else begin
        wbm_stall = 1'b0;
      end
      if (wbm_cyc && wbm_stb && wbm_stall) begin
        st_adr_q.push_back(32'(wbm_adr));
        st_dat_q.push_back(wbm_dat);
      end
      wbm_ack = ack_en && pend;
      if (wbm_ack) ack_cnt++;
      pend = wbm_cyc && wbm_stb && !wbm_stall;
      if (pend) begin
        wr_adr_q.push_back(32'(wbm_adr));
        wr_dat_q.push_back(wbm_dat);
        last_fire_cyc = cyc_no;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_adr_q.delete();
    wr_dat_q.delete();
    st_adr_q.delete();
    st_dat_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input bit l);
    int n = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_last  = l;
    while (!pix_ready && n < 2000) begin
      step();
      n++;
    end
    chk("ready_wait_bound", 32'(n < 2000), 32'd1);
    step();
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] fr[$], input bit last_flag);
    for (int i = 0; i < fr.size(); i++) begin
      send_byte(fr[i], last_flag && (i == fr.size() - 1));
    end
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 2000) begin
      step();
      n++;
    end
    chk("done_wait", 32'(done_cnt), 32'(target));
  endtask

  // Model: a frame of n bytes becomes ROWS writes, rows past n written as zero.
  task automatic check_burst(input string tag, input logic [7:0] fr[$], input int base);
    logic [7:0] exp;
    chk({tag, "_count"}, 32'(wr_adr_q.size() >= base + ROWS), 32'd1);
    if (wr_adr_q.size() >= base + ROWS) begin
      for (int i = 0; i < ROWS; i++) begin
        exp = (i < fr.size()) ? fr[i] : 8'h00;
        chk($sformatf("%s_adr%0d", tag, i), wr_adr_q[base + i], 32'(i));
        chk($sformatf("%s_dat%0d", tag, i), wr_dat_q[base + i], {24'h0, exp});
      end
    end
  endtask

  logic [7:0] fr[$];
  logic [7:0] fr2[$];
  int         d0, e0, a0, n, len;

  initial begin
    pix_valid = 1'b0;
    pix_data  = '0;
    pix_last  = 1'b0;
    wbm_stall = 1'b0;
    wbm_ack   = 1'b0;
    rst_n     = 1'b0;
    repeat (3) step();
    chk("rst_ready", 32'(pix_ready), 32'd0);
    chk("rst_cyc", 32'(wbm_cyc), 32'd0);
    chk("rst_stb", 32'(wbm_stb), 32'd0);
    chk("rst_we_sel", {27'd0, wbm_we, wbm_sel}, 32'd0);
    chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("ready_after_release", 32'(pix_ready), 32'd1);

    // Walking-one frame, no stall
    clear_mon();
    fr = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    d0 = done_cnt;
    send_frame(fr, 1'b0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready_low", 32'(pix_ready), 32'd0);
    wait_done(d0 + 1);
    chk("t1_cyc_low_at_done", 32'(wbm_cyc), 32'd0);
    chk("t1_ready_back", 32'(pix_ready), 32'd1);
    check_burst("t1", fr, 0);
    step();
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_done_once", 32'(done_cnt), 32'(d0 + 1));

    // Short frame with last
    clear_mon();
    fr = '{8'h7F};
    d0 = done_cnt;
    send_frame(fr, 1'b1);
    wait_done(d0 + 1);
    check_burst("t2", fr, 0);

    // Stall three cycles on row 2
    clear_mon();
    fr = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    stall_adr  = 2;
    stall_left = 3;
    d0 = done_cnt;
    send_frame(fr, 1'b0);
    wait_done(d0 + 1);
    stall_adr = -1;
    check_burst("t3", fr, 0);
    chk("t3_writes", 32'(wr_adr_q.size()), 32'(ROWS));
    chk("t3_stall_cycles", 32'(st_adr_q.size()), 32'd3);
    for (int i = 0; i < st_adr_q.size(); i++) begin
      chk($sformatf("t3_held_adr%0d", i), st_adr_q[i], 32'd2);
      chk($sformatf("t3_held_dat%0d", i), st_dat_q[i], {24'h0, fr[2]});
    end

    // Silent slave: timeout abort
    clear_mon();
    ack_en = 0;
    fr = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    e0 = err_cnt;
    d0 = done_cnt;
    send_frame(fr, 1'b0);
    n = 0;
    while (err_cnt == e0 && n < 600) begin
      step();
      n++;
    end
    chk("t4_err_seen", 32'(err_cnt), 32'(e0 + 1));
    chk("t4_idle_cycles", 32'(err_cyc - last_fire_cyc - 1), 32'(TIMEOUT));
    chk("t4_cyc_low", 32'(wbm_cyc), 32'd0);
    chk("t4_ready", 32'(pix_ready), 32'd1);
    chk("t4_writes", 32'(wr_adr_q.size()), 32'(ROWS));
    chk("t4_no_done", 32'(done_cnt), 32'(d0));
    step();
    chk("t4_err_pulse", 32'(err), 32'd0);
    ack_en = 1;

    // Reset mid-burst after two acks
    clear_mon();
    fr = '{8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h0F};
    a0 = ack_cnt;
    send_frame(fr, 1'b0);
    n = 0;
    while (ack_cnt < a0 + 2 && n < 200) begin
      step();
      n++;
    end
    chk("t5_two_acks", 32'(ack_cnt), 32'(a0 + 2));
    step();
    d0 = done_cnt;
    e0 = err_cnt;
    rst_n = 1'b0;
    #1;
    chk("t5_cyc_async", 32'(wbm_cyc), 32'd0);
    chk("t5_stb_async", 32'(wbm_stb), 32'd0);
    chk("t5_we_sel_async", {27'd0, wbm_we, wbm_sel}, 32'd0);
    repeat (3) step();
    chk("t5_no_done_err", 32'(done_cnt + err_cnt), 32'(d0 + e0));
    rst_n = 1'b1;
    clear_mon();
    step();
    fr = '{8'h12, 8'h34, 8'h56};
    d0 = done_cnt;
    send_frame(fr, 1'b1);
    wait_done(d0 + 1);
    check_burst("t5_after", fr, 0);

    // Ten bytes back-to-back: two bursts in order
    clear_mon();
    fr.delete();
    fr2.delete();
    for (int i = 0; i < 5; i++) fr.push_back(8'($urandom));
    for (int i = 0; i < 5; i++) fr2.push_back(8'($urandom));
    d0 = done_cnt;
    send_frame(fr, 1'b0);
    send_frame(fr2, 1'b0);
    wait_done(d0 + 2);
    check_burst("t6_a", fr, 0);
    check_burst("t6_b", fr2, ROWS);

    // Randomized frames with random stalls
    rand_stall = 1;
    for (int k = 0; k < 6; k++) begin
      clear_mon();
      fr.delete();
      len = int'($urandom_range(1, 5));
      for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
      d0 = done_cnt;
      send_frame(fr, (len < 5) ? 1'b1 : 1'($urandom_range(1)));
      wait_done(d0 + 1);
      check_burst($sformatf("rnd%0d", k), fr, 0);
    end
    rand_stall = 0;

    chk("done_err_exclusive", 32'(both_cnt), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
